// File: rtl/mod_n_cascade_counter.sv
// mod_n_cascade_counter: DIGITS cascaded modulo-RADIX up/down digits with
// sync clear, validated parallel load, terminal-count and carry-out for
// chaining instances.
// Optional build macro MOD_N_CASCADE_COUNTER_MATCH_EN adds match_val/match,
// a registered compare of the next count against match_val.
module mod_n_cascade_counter #(
  parameter int RADIX   = 10,
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        load,
  input  logic [DIGITS*DIGIT_W-1:0]   load_val,
  input  logic                        en,
  input  logic                        up,
  output logic [DIGITS*DIGIT_W-1:0]   q,
  output logic                        tc,
  output logic                        co,
  output logic                        load_err
`ifdef MOD_N_CASCADE_COUNTER_MATCH_EN
  ,
  input  logic [DIGITS*DIGIT_W-1:0]   match_val,
  output logic                        match
`endif
);

  localparam logic [DIGIT_W:0]   RADIX_X = (DIGIT_W+1)'(RADIX);
  localparam logic [DIGIT_W-1:0] TOP     = DIGIT_W'(RADIX - 1);

  logic [DIGITS*DIGIT_W-1:0] q_next;
  logic                      load_illegal;
  logic [DIGIT_W-1:0]        term;

  // Terminal digit value for the current direction.
  always_comb begin
    term = up ? TOP : '0;
  end

  // Next-count selection: clr > load > en > hold. Every digit's step enable is
  // the AND of "all lower digits terminal", so the whole cascade updates on one edge.
  always_comb begin
    logic               ripple;
    logic [DIGIT_W-1:0] d;
    q_next       = q;
    load_illegal = 1'b0;
    ripple       = 1'b1;
    d            = '0;
    if (clr) begin
      q_next = '0;
    end else if (load) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        d = load_val[i*DIGIT_W +: DIGIT_W];
        if ({1'b0, d} < RADIX_X) begin
          q_next[i*DIGIT_W +: DIGIT_W] = d;
        end else begin
          q_next[i*DIGIT_W +: DIGIT_W] = '0;
          load_illegal = 1'b1;
        end
      end
    end else if (en) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        d = q[i*DIGIT_W +: DIGIT_W];
        if (ripple) begin
          if (up) q_next[i*DIGIT_W +: DIGIT_W] = (d == TOP) ? '0 : d + 1'b1;
          else    q_next[i*DIGIT_W +: DIGIT_W] = (d == '0) ? TOP : d - 1'b1;
        end
        ripple = ripple & (d == term);
      end
    end
  end

  // Terminal count: all digits at the terminal value for the current direction.
  always_comb begin
    tc = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (q[i*DIGIT_W +: DIGIT_W] != term) tc = 1'b0;
    end
    co = tc & en;
  end

  // Count register and one-cycle load error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= '0;
      load_err <= 1'b0;
    end else begin
      q        <= q_next;
      load_err <= load_illegal;
    end
  end

`ifdef MOD_N_CASCADE_COUNTER_MATCH_EN
  // Registered compare against the next count so match aligns with q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      match <= 1'b0;
    else if (clr) match <= 1'b0;
    else          match <= (q_next == match_val);
  end
`endif

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// Bench for mod_n_cascade_counter: default decade instance plus a RADIX=6,
// DIGITS=2 instance, both checked against an integer-valued reference model.
module tb_mod_n_cascade_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  // default 4-digit decade instance
  logic        clr = 0, load = 0, en = 0, up = 1;
  logic [15:0] load_val = '0;
  logic [15:0] q;
  logic        tc, co, load_err;
  // RADIX=6, DIGITS=2 instance
  logic        clr6 = 0, load6 = 0, en6 = 0, up6 = 1;
  logic [7:0]  load_val6 = '0;
  logic [7:0]  q6;
  logic        tc6, co6, load_err6;
`ifdef MOD_N_CASCADE_COUNTER_MATCH_EN
  logic [15:0] mval = 16'h0000;
  logic        match;
  logic [7:0]  mval6 = 8'h23;
  logic        match6;
`endif

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int mv = 0, mv6 = 0;
  bit merr = 0, merr6 = 0;
  bit mm = 0, mm6 = 0;

  always #5 clk = ~clk;

  mod_n_cascade_counter #(.RADIX(10), .DIGITS(4), .DIGIT_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q), .tc(tc), .co(co), .load_err(load_err)
`ifdef MOD_N_CASCADE_COUNTER_MATCH_EN
    , .match_val(mval), .match(match)
`endif
  );

  mod_n_cascade_counter #(.RADIX(6), .DIGITS(2), .DIGIT_W(4)) dut6 (
    .clk(clk), .rst(rst), .clr(clr6), .load(load6), .load_val(load_val6),
    .en(en6), .up(up6), .q(q6), .tc(tc6), .co(co6), .load_err(load_err6)
`ifdef MOD_N_CASCADE_COUNTER_MATCH_EN
    , .match_val(mval6), .match(match6)
`endif
  );

  // Pack integer value v into 4-bit digits of the given radix.
  function automatic logic [31:0] enc(input int v, input int radix, input int digits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[i*4 +: 4] = 4'(v % radix);
      v = v / radix;
    end
    return r;
  endfunction

  // Integer value of a load word, illegal digits replaced by zero.
  function automatic int dec(input logic [31:0] lv, input int radix, input int digits,
                             output bit err);
    int v, d;
    v = 0;
    err = 0;
    for (int i = digits - 1; i >= 0; i--) begin
      d = int'(lv[i*4 +: 4]);
      if (d >= radix) begin
        err = 1;
        d = 0;
      end
      v = v * radix + d;
    end
    return v;
  endfunction

  function automatic int next_val(input int v, input int m, input int radix, input int digits,
                                  input bit c, input bit l, input bit e, input bit u,
                                  input logic [31:0] lv, output bit err);
    err = 0;
    if (c) return 0;
    if (l) return dec(lv, radix, digits, err);
    if (e) return u ? (v + 1) % m : (v + m - 1) % m;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("q", 32'(q), enc(mv, 10, 4));
    chk("load_err", 32'(load_err), 32'(merr));
    chk("tc", 32'(tc), 32'(up ? (mv == 9999) : (mv == 0)));
    chk("co", 32'(co), 32'(en && (up ? (mv == 9999) : (mv == 0))));
    chk("q6", 32'(q6), enc(mv6, 6, 2));
    chk("load_err6", 32'(load_err6), 32'(merr6));
    chk("co6", 32'(co6), 32'(en6 && (up6 ? (mv6 == 35) : (mv6 == 0))));
`ifdef MOD_N_CASCADE_COUNTER_MATCH_EN
    chk("match", 32'(match), 32'(mm));
    chk("match6", 32'(match6), 32'(mm6));
`endif
  endtask

  // One clock edge: advance the model from the current inputs, then compare.
  task automatic step();
    int nv, nv6;
    bit ne, ne6;
    nv  = next_val(mv, 10000, 10, 4, clr, load, en, up, 32'(load_val), ne);
    nv6 = next_val(mv6, 36, 6, 2, clr6, load6, en6, up6, 32'(load_val6), ne6);
`ifdef MOD_N_CASCADE_COUNTER_MATCH_EN
    mm  = !clr  && (enc(nv, 10, 4) == 32'(mval));
    mm6 = !clr6 && (enc(nv6, 6, 2) == 32'(mval6));
`endif
    @(posedge clk);
    #1;
    mv = nv; mv6 = nv6; merr = ne; merr6 = ne6;
    check_all();
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1; load_val = v;
    step();
    load = 0;
  endtask

  initial begin
    // power-up reset, released between edges
    #12;
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_err", 32'(load_err), 32'h0);
    rst = 0;
    step();

    // load with illegal digit, then reset pulse between edges
    do_load(16'h12A4);
    chk("load_12A4", 32'(q), 32'h1204);
    rst = 1; en = 1; up = 1;
    #2;
    mv = 0; mv6 = 0; merr = 0; merr6 = 0; mm = 0; mm6 = 0;
    chk("async_rst_q", 32'(q), 32'h0);
    chk("async_rst_err", 32'(load_err), 32'h0);
    chk("async_rst_tc", 32'(tc), 32'h0);
    chk("async_rst_co", 32'(co), 32'h0);
    rst = 0; en = 0;
    step();

    // load validation: error pulse lasts exactly one cycle
    do_load(16'h12A4);
    chk("load_err_pulse", 32'(load_err), 32'h1);
    step();
    chk("load_err_clear", 32'(load_err), 32'h0);
    do_load(16'h5678);
    chk("load_5678", 32'(q), 32'h5678);

    // full up count over every value of both instances
    clr = 1; clr6 = 1;
    step();
    clr = 0; clr6 = 0;
    en = 1; up = 1; en6 = 1; up6 = 1;
    for (int i = 0; i < 10000; i++) step();
    chk("wrap_up", 32'(q), 32'h0000);
    for (int i = 0; i < 9999; i++) step();
    chk("at_9999", 32'(q), 32'h9999);
    chk("tc_9999", 32'(tc), 32'h1);
    // direction change moves tc without an edge
    up = 0;
    #1;
    chk("tc_dir_change", 32'(tc), 32'h0);
    en = 0; en6 = 0;

    // down count with borrow
    do_load(16'h1000);
    en = 1;
    step();
    chk("borrow", 32'(q), 32'h0999);
    en = 0;
    do_load(16'h0000);
    chk("tc_down_zero", 32'(tc), 32'h1);
    en = 1;
    step();
    chk("wrap_down", 32'(q), 32'h9999);

    // priority
    up = 1; en = 0;
    do_load(16'h0042);
    clr = 1; load = 1; en = 1; load_val = 16'h1111;
    step();
    chk("clr_priority", 32'(q), 32'h0);
    clr = 0;
    do_load(16'h0007);
    chk("load_over_en", 32'(q), 32'h0007);
    en = 0;
    do_load(16'h0009);
    step();
    chk("hold", 32'(q), 32'h0009);
    chk("co_hold", 32'(co), 32'h0);

    // random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) == 1;
      load_val = 16'($urandom);
      clr6  = ($urandom_range(0, 19) == 0);
      load6 = ($urandom_range(0, 7) == 0);
      en6   = ($urandom_range(0, 3) != 0);
      up6   = $urandom_range(0, 1) == 1;
      load_val6 = 8'($urandom);
`ifdef MOD_N_CASCADE_COUNTER_MATCH_EN
      if ($urandom_range(0, 15) == 0) mval = 16'($urandom);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
